// File: rtl/prio_grant_decoder.sv
// prio_grant_decoder: expands an accepted 3-bit index into a held one-hot grant with a done pulse.
// Optional feature macro: PRIO_GRANT_SERVED_EN (served mask, clear and repeat-index reject).
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   code_in/valid     index handshake input, code_ready high only in IDLE
//   release_in        early release of the current grant
//   grant_out         registered one-hot grant, grant_active = |grant_out
//   grant_done        one-cycle pulse when a grant ends
//   clear_served      clears served_mask (served build only)
//   served_mask       requesters granted since last clear (served build only)
//   grant_reject      one-cycle pulse when an already-served index is accepted (served build only)
module prio_grant_decoder #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] code_in,
    input  logic       code_valid,
    output logic       code_ready,
    input  logic       release_in,
    output logic [7:0] grant_out,
    output logic       grant_active,
    output logic       grant_done
`ifdef PRIO_GRANT_SERVED_EN
    ,
    input  logic       clear_served,
    output logic [7:0] served_mask,
    output logic       grant_reject
`endif
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] grant_q, grant_d;
    logic       done_q, done_d;
`ifdef PRIO_GRANT_SERVED_EN
    logic [7:0] mask_q, mask_d;
    logic       reject_q, reject_d;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        done_d  = 1'b0;
`ifdef PRIO_GRANT_SERVED_EN
        reject_d = 1'b0;
        // clear applies before any bit set by a coincident acceptance
        mask_d   = clear_served ? 8'h00 : mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (code_valid) begin
`ifdef PRIO_GRANT_SERVED_EN
                    if (mask_d[code_in]) begin
                        reject_d = 1'b1;
                        state_d  = GAP;
                    end else begin
                        mask_d[code_in] = 1'b1;
                        grant_d = 8'(1) << code_in;
                        cnt_d   = 8'(HOLD_CYCLES - 1);
                        state_d = GRANT;
                    end
`else
                    grant_d = 8'(1) << code_in;
                    cnt_d   = 8'(HOLD_CYCLES - 1);
                    state_d = GRANT;
`endif
                end
            end
            GRANT: begin
                // expiry and release together still end the grant once
                if (cnt_q == 8'd0 || release_in) begin
                    grant_d = 8'h00;
                    done_d  = 1'b1;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            grant_q  <= 8'h00;
            done_q   <= 1'b0;
`ifdef PRIO_GRANT_SERVED_EN
            mask_q   <= 8'h00;
            reject_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
`ifdef PRIO_GRANT_SERVED_EN
            mask_q   <= mask_d;
            reject_q <= reject_d;
`endif
        end
    end
    assign code_ready   = state_q == IDLE;
    assign grant_out    = grant_q;
    assign grant_active = |grant_q;
    assign grant_done   = done_q;
`ifdef PRIO_GRANT_SERVED_EN
    assign served_mask  = mask_q;
    assign grant_reject = reject_q;
`endif
endmodule

// File: tb/tb_prio_grant_decoder.sv
// tb_prio_grant_decoder: randomized scoreboard bench for prio_grant_decoder plus a HOLD_CYCLES=1 sweep.
module tb_prio_grant_decoder;
    localparam int H = 4;
    logic       clk, rst_n;
    logic [2:0] code_in;
    logic       code_valid, code_ready, release_in, grant_active, grant_done, clear_served;
    logic [7:0] grant_out;
    logic [2:0] c1;
    logic       v1, r1, a1, d1;
    logic [7:0] g1;
`ifdef PRIO_GRANT_SERVED_EN
    logic [7:0] served_mask, m1;
    logic       grant_reject, j1;
`endif
    prio_grant_decoder #(.HOLD_CYCLES(H)) u_dut (
        .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
        .code_ready(code_ready), .release_in(release_in), .grant_out(grant_out),
        .grant_active(grant_active), .grant_done(grant_done)
`ifdef PRIO_GRANT_SERVED_EN
        , .clear_served(clear_served), .served_mask(served_mask), .grant_reject(grant_reject)
`endif
    );
    prio_grant_decoder #(.HOLD_CYCLES(1)) u_one (
        .clk(clk), .rst_n(rst_n), .code_in(c1), .code_valid(v1),
        .code_ready(r1), .release_in(1'b0), .grant_out(g1),
        .grant_active(a1), .grant_done(d1)
`ifdef PRIO_GRANT_SERVED_EN
        , .clear_served(1'b0), .served_mask(m1), .grant_reject(j1)
`endif
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    typedef struct {
        logic [2:0] code;
        int         len;
        bit         rej;
    } exp_t;
    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] m_mask = 8'h00;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Called at a negedge; returns at the negedge of the last possible grant cycle.
    task automatic send(input logic [2:0] c, input int k, input bit clr);
        int   w = 0;
        exp_t e;
        code_valid   = 1'b1;
        code_in      = c;
        clear_served = clr;
        while (!code_ready && w < 50) begin
            @(negedge clk);
            release_in = 1'($urandom % 2);
            w++;
        end
        if (!code_ready) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout: code_ready stayed 0 for %0d cycles", w);
            code_valid = 1'b0;
            return;
        end
        if (clr) m_mask = 8'h00;
        e.code = c;
        e.len  = (k >= 1 && k < H) ? k : H;
`ifdef PRIO_GRANT_SERVED_EN
        e.rej = m_mask[c];
        m_mask[c] = 1'b1;
`else
        e.rej = 1'b0;
`endif
        sb.push_back(e);
        @(negedge clk);
        code_valid   = 1'b0;
        clear_served = 1'b0;
        release_in   = (k == 1);
        for (int i = 2; i <= H; i++) begin
            @(negedge clk);
            release_in = (k == i);
        end
    endtask
    logic [7:0] g;
    int         len = 0;
    bit         prev_end = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            len = 0;
            prev_end = 0;
        end else begin
            if (code_valid && $isunknown(code_in)) begin
                total++;
                bad++;
                $display("FAIL code_x: code_in=%b with code_valid high", code_in);
            end
            chk("active", grant_active, {31'd0, |grant_out});
            if (prev_end) chk("ready_after_gap", code_ready, 1);
            if (grant_out != 8'h00) begin
                chk("onehot", {31'd0, $onehot(grant_out)}, 1);
                chk("ready_busy", code_ready, 0);
                if (len == 0) g = grant_out;
                else chk("grant_stable", grant_out, g);
                len++;
            end
            prev_end = grant_done;
`ifdef PRIO_GRANT_SERVED_EN
            prev_end = prev_end || grant_reject;
`endif
            if (grant_done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done: grant_done=1 with no pending grant");
                end else begin
                    e = sb.pop_front();
                    chk("done_code", g, 8'(1) << e.code);
                    chk("done_len", len, e.len);
                    chk("done_rej", {31'd0, e.rej}, 0);
                    chk("done_cleared", grant_out, 0);
                    chk("done_ready", code_ready, 0);
                end
                len = 0;
            end
`ifdef PRIO_GRANT_SERVED_EN
            if (grant_reject) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_reject: grant_reject=1 with no pending code");
                end else begin
                    e = sb.pop_front();
                    chk("reject_expected", {31'd0, e.rej}, 1);
                    chk("reject_no_grant", grant_out, 0);
                    chk("reject_ready", code_ready, 0);
                end
            end
`endif
        end
    end
    initial begin
        int w;
        rst_n = 1'b0;
        code_valid = 1'b0;
        code_in = 3'd0;
        release_in = 1'b0;
        clear_served = 1'b0;
        v1 = 1'b0;
        c1 = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_grant", grant_out, 0);
        chk("rst_ready", code_ready, 1);
        chk("rst_done", grant_done, 0);
        chk("rst_active", grant_active, 0);
        rst_n = 1'b1;
        @(negedge clk);
        send(3'd5, 0, 0);
        send(3'd0, 2, 0);
        send(3'd7, 0, 0);
        repeat (3) @(negedge clk);
        code_valid = 1'b1;
        code_in = 3'd3;
        chk("rst_mid_ready", code_ready, 1);
        @(negedge clk);
        code_valid = 1'b0;
        chk("rst_mid_grant", grant_out, 8'h08);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_cleared", grant_out, 0);
        chk("rst_mid_idle", code_ready, 1);
        chk("rst_mid_nodone", grant_done, 0);
        m_mask = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (H + 2) @(negedge clk);
`ifdef PRIO_GRANT_SERVED_EN
        send(3'd2, 0, 0);
        send(3'd2, 0, 0);
        chk("served_after_reject", served_mask, 8'h04);
        send(3'd2, 0, 1);
        chk("served_after_clear", served_mask, 8'h04);
`endif
        for (int n = 0; n < 200; n++)
            send(3'($urandom % 8), int'($urandom_range(0, H + 1)), ($urandom % 5) == 0);
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected grants never completed", sb.size());
        end
        for (int c = 0; c < 8; c++) begin
            v1 = 1'b1;
            c1 = 3'(c);
            chk("one_ready", r1, 1);
            @(negedge clk);
            v1 = 1'b0;
            chk("one_grant", g1, 8'(1) << c);
            chk("one_nodone", d1, 0);
            @(negedge clk);
            chk("one_cleared", g1, 0);
            chk("one_done", d1, 1);
            chk("one_gap", r1, 0);
            @(negedge clk);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
